cp_fifo_flow_ctrl: RTL and testbench

- Flow/sequencing controller for the CP command FIFO in main memory. It sits between the write-gather pipe (producer) and the CP command fetcher (consumer).
- Tracks the CP read pointer and the read/write distance, and gates fetch requests.
- Raises the high/low watermark and breakpoint interrupts exposed through the CP registers.
- All FIFO accounting is in 32-byte lines.

---
 rtl/cp_pkg.sv | 19 +
 rtl/cp_fifo_irq_latch.sv | 32 +++
 rtl/cp_fifo_flow_ctrl.sv | 161 ++++++++++++++++
 tb/tb_cp_fifo_flow_ctrl.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/cp_pkg.sv
// Shared definitions for the CP command FIFO flow controller.
package cp_pkg;

  localparam int unsigned ADDR_W     = 32;
  localparam int unsigned LINE_SHIFT = 5;
  localparam int unsigned DIST_W     = ADDR_W - LINE_SHIFT;
  localparam int unsigned ERR_W      = 16;

  // Bit positions inside FIFOErrors
  localparam int unsigned ERR_DIST_SAT       = 0;
  localparam int unsigned ERR_FETCH_UNDERRUN = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_BREAK = 2'd2
  } cp_state_e;

endpackage

// File: rtl/cp_fifo_irq_latch.sv
// Sticky interrupt bit: gated set wins over clear, held until cleared or restarted.
module cp_fifo_irq_latch (
  input  logic clk,
  input  logic reset,
  input  logic enable_i,
  input  logic set_i,
  input  logic clear_i,
  output logic irq_o
);

  logic irq_q, irq_d;

  always_comb begin
    irq_d = irq_q;
    if (enable_i && set_i) begin
      irq_d = 1'b1;
    end else if (clear_i) begin
      irq_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign irq_o = irq_q;

endmodule

// File: rtl/cp_fifo_flow_ctrl.sv
// CP command FIFO flow controller: read pointer, line distance, fetch gating,
// watermark and breakpoint interrupts. All accounting is in 32-byte lines.
module cp_fifo_flow_ctrl #(
  parameter int unsigned LINE_SHIFT = cp_pkg::LINE_SHIFT,
  parameter int unsigned DIST_W     = cp_pkg::DIST_W
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] FIFOBase,
  input  logic [31:0] FIFOEnd,
  input  logic [31:0] FIFOHighWatermark,
  input  logic [31:0] FIFOLowWatermark,
  input  logic [31:0] FIFOBreakpoint,
  input  logic        FIFONewBase,
  input  logic        readEnable,
  input  logic        bpEnable,
  input  logic        hiIntEnable,
  input  logic        loIntEnable,
  input  logic        clearHi,
  input  logic        clearLo,
  input  logic        clearBp,
  input  logic        lineCommit,
  output logic        fetchRequest,
  input  logic        fetchDone,
  output logic [31:0] FIFOReadPointer,
  output logic [31:0] FIFODistance,
  output logic        hiIrq,
  output logic        loIrq,
  output logic        bpIrq,
  output logic [15:0] FIFOErrors
);

  import cp_pkg::*;

  localparam int unsigned LINE_W = 32 - LINE_SHIFT;

  cp_state_e         state_q, state_d;
  logic [LINE_W-1:0] read_line_q, read_line_d;
  logic [DIST_W-1:0] dist_q, dist_d;
  logic              sat_err_q, sat_err_d;
  logic              underrun_err_q, underrun_err_d;

  logic [LINE_W-1:0] base_line, end_line, bp_line;
  logic              restart_c, dist_zero_c, bp_hit_c, fetch_ok_c;
  logic [31:0]       dist_bytes_c;
  logic [ERR_W-1:0]  errors_c;
  logic              unused_lsbs;

  assign base_line   = FIFOBase[31:LINE_SHIFT];
  assign end_line    = FIFOEnd[31:LINE_SHIFT];
  assign bp_line     = FIFOBreakpoint[31:LINE_SHIFT];
  assign unused_lsbs = ^{FIFOBase[LINE_SHIFT-1:0], FIFOEnd[LINE_SHIFT-1:0],
                         FIFOBreakpoint[LINE_SHIFT-1:0]};

  // A rebase restarts accounting exactly like reset
  assign restart_c   = reset | FIFONewBase;
  assign dist_zero_c = (dist_q == '0);
  assign bp_hit_c    = (state_q == ST_RUN) & bpEnable & (read_line_q == bp_line) & ~dist_zero_c;
  assign fetchRequest = (state_q == ST_RUN) & ~dist_zero_c & ~bp_hit_c;
  assign fetch_ok_c  = fetchDone & fetchRequest;

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (readEnable) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (!readEnable)   state_d = ST_IDLE;
        else if (bp_hit_c) state_d = ST_BREAK;
      end
      ST_BREAK: begin
        if (clearBp) state_d = readEnable ? ST_RUN : ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pointer, distance and error accounting
  always_comb begin
    read_line_d    = read_line_q;
    dist_d         = dist_q;
    sat_err_d      = sat_err_q;
    underrun_err_d = underrun_err_q;

    if (fetch_ok_c) begin
      read_line_d = (read_line_q == end_line) ? base_line : read_line_q + LINE_W'(1);
    end

    if (lineCommit && !fetch_ok_c) begin
      if (dist_q == '1) begin
        sat_err_d = 1'b1;
      end else begin
        dist_d = dist_q + DIST_W'(1);
      end
    end else if (fetch_ok_c && !lineCommit) begin
      dist_d = dist_q - DIST_W'(1);
    end

    if (fetchDone && !fetchRequest) begin
      underrun_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (restart_c) begin
      state_q        <= ST_IDLE;
      read_line_q    <= base_line;
      dist_q         <= '0;
      sat_err_q      <= 1'b0;
      underrun_err_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      read_line_q    <= read_line_d;
      dist_q         <= dist_d;
      sat_err_q      <= sat_err_d;
      underrun_err_q <= underrun_err_d;
    end
  end

  assign dist_bytes_c    = 32'({dist_q, {LINE_SHIFT{1'b0}}});
  assign FIFODistance    = dist_bytes_c;
  assign FIFOReadPointer = {read_line_q, {LINE_SHIFT{1'b0}}};

  always_comb begin
    errors_c                     = '0;
    errors_c[ERR_DIST_SAT]       = sat_err_q;
    errors_c[ERR_FETCH_UNDERRUN] = underrun_err_q;
  end
  assign FIFOErrors = errors_c;

  cp_fifo_irq_latch u_hi_irq (
    .clk      (clk),
    .reset    (restart_c),
    .enable_i (hiIntEnable),
    .set_i    (dist_bytes_c > FIFOHighWatermark),
    .clear_i  (clearHi),
    .irq_o    (hiIrq)
  );

  cp_fifo_irq_latch u_lo_irq (
    .clk      (clk),
    .reset    (restart_c),
    .enable_i (loIntEnable),
    .set_i    (dist_bytes_c < FIFOLowWatermark),
    .clear_i  (clearLo),
    .irq_o    (loIrq)
  );

  // Breakpoint IRQ fires on the RUN -> BREAK transition
  cp_fifo_irq_latch u_bp_irq (
    .clk      (clk),
    .reset    (restart_c),
    .enable_i (1'b1),
    .set_i    ((state_q == ST_RUN) && (state_d == ST_BREAK)),
    .clear_i  (clearBp),
    .irq_o    (bpIrq)
  );

endmodule

// File: tb/tb_cp_fifo_flow_ctrl.sv
// Self-checking bench for cp_fifo_flow_ctrl: vector table plus hand-written IRQ/breakpoint/rebase sequences.
module tb_cp_fifo_flow_ctrl;

  localparam logic [31:0] BASE      = 32'h0000_1000;
  localparam logic [31:0] END_BIG   = 32'h0000_1FE0;
  localparam logic [31:0] END_SMALL = 32'h0000_1040;

  localparam int SEL_DIST = 0;
  localparam int SEL_PTR  = 1;
  localparam int SEL_FREQ = 2;
  localparam int SEL_HI   = 3;
  localparam int SEL_LO   = 4;
  localparam int SEL_BP   = 5;
  localparam int SEL_ERR  = 6;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] FIFOBase, FIFOEnd, FIFOHighWatermark, FIFOLowWatermark, FIFOBreakpoint;
  logic        FIFONewBase, readEnable, bpEnable, hiIntEnable, loIntEnable;
  logic        clearHi, clearLo, clearBp, lineCommit, fetchDone;
  logic        fetchRequest, hiIrq, loIrq, bpIrq;
  logic [31:0] FIFOReadPointer, FIFODistance;
  logic [15:0] FIFOErrors;

  always #5 clk = ~clk;

  cp_fifo_flow_ctrl dut (
    .clk               (clk),
    .reset             (reset),
    .FIFOBase          (FIFOBase),
    .FIFOEnd           (FIFOEnd),
    .FIFOHighWatermark (FIFOHighWatermark),
    .FIFOLowWatermark  (FIFOLowWatermark),
    .FIFOBreakpoint    (FIFOBreakpoint),
    .FIFONewBase       (FIFONewBase),
    .readEnable        (readEnable),
    .bpEnable          (bpEnable),
    .hiIntEnable       (hiIntEnable),
    .loIntEnable       (loIntEnable),
    .clearHi           (clearHi),
    .clearLo           (clearLo),
    .clearBp           (clearBp),
    .lineCommit        (lineCommit),
    .fetchRequest      (fetchRequest),
    .fetchDone         (fetchDone),
    .FIFOReadPointer   (FIFOReadPointer),
    .FIFODistance      (FIFODistance),
    .hiIrq             (hiIrq),
    .loIrq             (loIrq),
    .bpIrq             (bpIrq),
    .FIFOErrors        (FIFOErrors)
  );

  typedef struct {
    string       name;
    int          sel;
    logic [31:0] val;
  } exp_t;

  typedef struct {
    logic        nb;
    logic [31:0] fend;
    logic        ren;
    logic        commit;
    logic        fdone;
    logic [31:0] x_dist;
    logic [31:0] x_ptr;
    logic        x_freq;
    logic [15:0] x_err;
  } vec_t;

  exp_t sb[$];
  int   n_vec = 0;
  int   n_bad = 0;
  int   nfetch;

  localparam int NV = 22;
  vec_t vt [NV];

  function automatic vec_t mkv(input logic nb, input logic [31:0] fend, input logic ren,
                               input logic commit, input logic fdone, input logic [31:0] xd,
                               input logic [31:0] xp, input logic xf, input logic [15:0] xe);
    vec_t v;
    v.nb = nb; v.fend = fend; v.ren = ren; v.commit = commit; v.fdone = fdone;
    v.x_dist = xd; v.x_ptr = xp; v.x_freq = xf; v.x_err = xe;
    return v;
  endfunction

  function automatic logic [31:0] dut_val(input int sel);
    case (sel)
      SEL_DIST: return FIFODistance;
      SEL_PTR:  return FIFOReadPointer;
      SEL_FREQ: return 32'(fetchRequest);
      SEL_HI:   return 32'(hiIrq);
      SEL_LO:   return 32'(loIrq);
      SEL_BP:   return 32'(bpIrq);
      default:  return 32'(FIFOErrors);
    endcase
  endfunction

  task automatic check_now(input string n, input logic [31:0] act, input logic [31:0] req);
    n_vec++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", n, act, req);
    end
  endtask

  task automatic expect_v(input string n, input int sel, input logic [31:0] v);
    exp_t e;
    e.name = n; e.sel = sel; e.val = v;
    sb.push_back(e);
  endtask

  // One clock: expectations queued before the edge are checked just after it
  task automatic tick();
    exp_t e;
    @(posedge clk);
    #1;
    while (sb.size() != 0) begin
      e = sb.pop_front();
      check_now(e.name, dut_val(e.sel), e.val);
    end
    FIFONewBase = 1'b0; lineCommit = 1'b0; fetchDone = 1'b0;
    clearHi = 1'b0; clearLo = 1'b0; clearBp = 1'b0;
  endtask

  // Acts as the fetcher: accepts whenever a request is visible, bounded by cycles
  task automatic fetch_cycles(input int cycles, output int count);
    count = 0;
    for (int i = 0; i < cycles; i++) begin
      fetchDone = fetchRequest;
      if (fetchRequest) count++;
      tick();
    end
  endtask

  initial begin
    vt[0]  = mkv(1'b0, END_BIG,   1'b1, 1'b1, 1'b0, 32'h20, 32'h1000, 1'b1, 16'h0);
    vt[1]  = mkv(1'b0, END_BIG,   1'b1, 1'b1, 1'b0, 32'h40, 32'h1000, 1'b1, 16'h0);
    vt[2]  = mkv(1'b0, END_BIG,   1'b1, 1'b1, 1'b0, 32'h60, 32'h1000, 1'b1, 16'h0);
    vt[3]  = mkv(1'b0, END_BIG,   1'b1, 1'b0, 1'b1, 32'h40, 32'h1020, 1'b1, 16'h0);
    vt[4]  = mkv(1'b0, END_BIG,   1'b1, 1'b0, 1'b1, 32'h20, 32'h1040, 1'b1, 16'h0);
    vt[5]  = mkv(1'b0, END_BIG,   1'b1, 1'b0, 1'b1, 32'h00, 32'h1060, 1'b0, 16'h0);
    vt[6]  = mkv(1'b1, END_SMALL, 1'b1, 1'b0, 1'b0, 32'h00, 32'h1000, 1'b0, 16'h0);
    vt[7]  = mkv(1'b0, END_SMALL, 1'b1, 1'b1, 1'b0, 32'h20, 32'h1000, 1'b1, 16'h0);
    vt[8]  = mkv(1'b0, END_SMALL, 1'b1, 1'b1, 1'b0, 32'h40, 32'h1000, 1'b1, 16'h0);
    vt[9]  = mkv(1'b0, END_SMALL, 1'b1, 1'b1, 1'b0, 32'h60, 32'h1000, 1'b1, 16'h0);
    vt[10] = mkv(1'b0, END_SMALL, 1'b1, 1'b1, 1'b0, 32'h80, 32'h1000, 1'b1, 16'h0);
    vt[11] = mkv(1'b0, END_SMALL, 1'b1, 1'b0, 1'b1, 32'h60, 32'h1020, 1'b1, 16'h0);
    vt[12] = mkv(1'b0, END_SMALL, 1'b1, 1'b0, 1'b1, 32'h40, 32'h1040, 1'b1, 16'h0);
    vt[13] = mkv(1'b0, END_SMALL, 1'b1, 1'b0, 1'b1, 32'h20, 32'h1000, 1'b1, 16'h0);
    vt[14] = mkv(1'b0, END_SMALL, 1'b1, 1'b1, 1'b0, 32'h40, 32'h1000, 1'b1, 16'h0);
    vt[15] = mkv(1'b0, END_SMALL, 1'b1, 1'b1, 1'b1, 32'h40, 32'h1020, 1'b1, 16'h0);
    vt[16] = mkv(1'b0, END_SMALL, 1'b1, 1'b0, 1'b1, 32'h20, 32'h1040, 1'b1, 16'h0);
    vt[17] = mkv(1'b0, END_SMALL, 1'b1, 1'b0, 1'b1, 32'h00, 32'h1000, 1'b0, 16'h0);
    vt[18] = mkv(1'b0, END_SMALL, 1'b1, 1'b0, 1'b1, 32'h00, 32'h1000, 1'b0, 16'h2);
    vt[19] = mkv(1'b0, END_SMALL, 1'b0, 1'b1, 1'b0, 32'h20, 32'h1000, 1'b0, 16'h2);
    vt[20] = mkv(1'b0, END_SMALL, 1'b1, 1'b0, 1'b0, 32'h20, 32'h1000, 1'b1, 16'h2);
    vt[21] = mkv(1'b1, END_SMALL, 1'b1, 1'b0, 1'b0, 32'h00, 32'h1000, 1'b0, 16'h0);

    reset = 1'b1;
    FIFOBase = BASE; FIFOEnd = END_BIG;
    FIFOHighWatermark = 32'hFFFF_FFFF; FIFOLowWatermark = 32'h0; FIFOBreakpoint = 32'h0;
    FIFONewBase = 1'b0; readEnable = 1'b0; bpEnable = 1'b0;
    hiIntEnable = 1'b0; loIntEnable = 1'b0;
    clearHi = 1'b0; clearLo = 1'b0; clearBp = 1'b0; lineCommit = 1'b0; fetchDone = 1'b0;

    // Reset state
    tick();
    expect_v("rst_dist", SEL_DIST, 32'h0);
    expect_v("rst_ptr",  SEL_PTR,  32'h1000);
    expect_v("rst_freq", SEL_FREQ, 32'h0);
    expect_v("rst_hi",   SEL_HI,   32'h0);
    expect_v("rst_lo",   SEL_LO,   32'h0);
    expect_v("rst_bp",   SEL_BP,   32'h0);
    expect_v("rst_err",  SEL_ERR,  32'h0);
    tick();
    reset = 1'b0;

    // Basic flow, wrap, simultaneous commit/fetch, underrun error
    for (int i = 0; i < NV; i++) begin
      FIFOEnd     = vt[i].fend;
      FIFONewBase = vt[i].nb;
      readEnable  = vt[i].ren;
      lineCommit  = vt[i].commit;
      fetchDone   = vt[i].fdone;
      expect_v($sformatf("v%0d_dist", i), SEL_DIST, vt[i].x_dist);
      expect_v($sformatf("v%0d_ptr",  i), SEL_PTR,  vt[i].x_ptr);
      expect_v($sformatf("v%0d_freq", i), SEL_FREQ, 32'(vt[i].x_freq));
      expect_v($sformatf("v%0d_err",  i), SEL_ERR,  32'(vt[i].x_err));
      tick();
    end

    // High watermark latency, set-over-clear, sticky after enable drop; low watermark
    FIFOEnd = END_BIG; FIFOHighWatermark = 32'h40; hiIntEnable = 1'b1; readEnable = 1'b1;
    for (int i = 0; i < 3; i++) begin
      lineCommit = 1'b1;
      expect_v($sformatf("hi_c%0d", i), SEL_HI, 32'h0);
      tick();
    end
    expect_v("hi_dist", SEL_DIST, 32'h60);
    expect_v("hi_rise", SEL_HI, 32'h1);
    tick();
    clearHi = 1'b1;
    expect_v("hi_clr_blocked", SEL_HI, 32'h1);
    tick();
    hiIntEnable = 1'b0;
    fetchDone = 1'b1;
    tick();
    fetchDone = 1'b1;
    expect_v("hi_sticky_dist", SEL_DIST, 32'h20);
    expect_v("hi_sticky", SEL_HI, 32'h1);
    tick();
    clearHi = 1'b1;
    expect_v("hi_cleared", SEL_HI, 32'h0);
    tick();
    FIFOLowWatermark = 32'h40; loIntEnable = 1'b1;
    expect_v("lo_rise", SEL_LO, 32'h1);
    tick();
    clearLo = 1'b1;
    expect_v("lo_clr_blocked", SEL_LO, 32'h1);
    tick();
    loIntEnable = 1'b0; clearLo = 1'b1;
    expect_v("lo_cleared", SEL_LO, 32'h0);
    tick();

    // Breakpoint: one fetch, then BREAK; clearBp resumes fetching
    FIFOBreakpoint = 32'h1020; bpEnable = 1'b1; FIFONewBase = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      lineCommit = 1'b1;
      tick();
    end
    fetch_cycles(6, nfetch);
    check_now("bp_fetch_count", 32'(nfetch), 32'h1);
    expect_v("bp_irq",  SEL_BP,   32'h1);
    expect_v("bp_freq", SEL_FREQ, 32'h0);
    expect_v("bp_ptr",  SEL_PTR,  32'h1020);
    expect_v("bp_dist", SEL_DIST, 32'h60);
    tick();
    bpEnable = 1'b0; clearBp = 1'b1;
    expect_v("bp_released", SEL_BP,   32'h0);
    expect_v("bp_resume",   SEL_FREQ, 32'h1);
    tick();
    fetch_cycles(6, nfetch);
    check_now("bp_resume_count", 32'(nfetch), 32'h3);
    expect_v("bp_end_dist", SEL_DIST, 32'h0);
    expect_v("bp_end_ptr",  SEL_PTR,  32'h1080);
    expect_v("bp_end_err",  SEL_ERR,  32'h0);
    tick();

    // Rebase mid-run with distance 5 and hiIrq set, then a spurious fetchDone
    FIFOHighWatermark = 32'h40; hiIntEnable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      lineCommit = 1'b1;
      tick();
    end
    expect_v("nb_pre_dist", SEL_DIST, 32'hA0);
    expect_v("nb_pre_hi",   SEL_HI,   32'h1);
    tick();
    FIFOBase = 32'h2000; FIFONewBase = 1'b1;
    expect_v("nb_dist", SEL_DIST, 32'h0);
    expect_v("nb_ptr",  SEL_PTR,  32'h2000);
    expect_v("nb_hi",   SEL_HI,   32'h0);
    expect_v("nb_freq", SEL_FREQ, 32'h0);
    expect_v("nb_err",  SEL_ERR,  32'h0);
    tick();
    fetchDone = 1'b1;
    expect_v("spur_err",  SEL_ERR,  32'h2);
    expect_v("spur_dist", SEL_DIST, 32'h0);
    expect_v("spur_ptr",  SEL_PTR,  32'h2000);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
